// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU load/store stage (port 0) and a loader/debug master (port 1).
// Each winning command is registered, driven to memory for one cycle, and completed with rvalid/rdata/err.
module dmem_arbiter #(
  parameter int AW       = 12,
  parameter bit ARB_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [3:0]    p0_wmem,
  input  logic [4:0]    p0_rmem,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic [3:0]    p1_wmem,
  input  logic [4:0]    p1_rmem,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic [3:0]    wmem,
  output logic [4:0]    rmem,
  output logic [31:0]   mem_addr,
  output logic [31:0]   store_data,
  input  logic [31:0]   load_data,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          last_gnt_q, last_gnt_d;
  logic          pick;
  logic [3:0]    cmd_wmem_q, cmd_wmem_d;
  logic [4:0]    cmd_rmem_q, cmd_rmem_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_wdata_q, cmd_wdata_d;
  logic          cmd_bad_q, cmd_bad_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic [31:0]   rd_val;

  function automatic logic lanes_legal(input logic [3:0] lanes);
    case (lanes)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: lanes_legal = 1'b1;
      default:                   lanes_legal = 1'b0;
    endcase
  endfunction

  function automatic logic wmem_legal(input logic [3:0] code);
    wmem_legal = (code == 4'b0000) || lanes_legal(code);
  endfunction

  // A sign-extended full word has no meaning, so 11111 is rejected along with bad lane masks.
  function automatic logic rmem_legal(input logic [4:0] code);
    rmem_legal = (code == 5'b00000) ||
                 (lanes_legal(code[3:0]) && !(code[4] && code[3:0] == 4'b1111));
  endfunction

  function automatic logic [31:0] load_result(input logic bad, input logic [4:0] code,
                                              input logic [31:0] data);
    load_result = (bad || code == 5'b00000) ? 32'h0 : data;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (p0_req || p1_req) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration: round-robin favours the port not granted last; fixed mode always favours port 0.
  always_comb begin
    if (ARB_MODE)                pick = ~p0_req;
    else if (p0_req && p1_req)   pick = ~last_gnt_q;
    else                         pick = p1_req;
  end

  // IDLE -> ACCESS: latch the winning command
  always_comb begin
    win_d       = win_q;
    cmd_wmem_d  = cmd_wmem_q;
    cmd_rmem_d  = cmd_rmem_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_bad_d   = cmd_bad_q;
    if (state_q == IDLE && (p0_req || p1_req)) begin
      win_d       = pick;
      cmd_wmem_d  = pick ? p1_wmem  : p0_wmem;
      cmd_rmem_d  = pick ? p1_rmem  : p0_rmem;
      cmd_addr_d  = pick ? p1_addr  : p0_addr;
      cmd_wdata_d = pick ? p1_wdata : p0_wdata;
      cmd_bad_d   = !(wmem_legal(cmd_wmem_d) && rmem_legal(cmd_rmem_d));
    end
  end

  // ACCESS -> IDLE: capture completion for the winner
  always_comb begin
    last_gnt_d = last_gnt_q;
    rvalid_d   = 2'b00;
    err_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rd_val     = load_result(cmd_bad_q, cmd_rmem_q, load_data);
    if (state_q == ACCESS) begin
      last_gnt_d      = win_q;
      rvalid_d[win_q] = 1'b1;
      err_d[win_q]    = cmd_bad_q;
      if (win_q) rdata1_d = rd_val;
      else       rdata0_d = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      win_q      <= win_d;
      last_gnt_q <= last_gnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_wmem_q  <= cmd_wmem_d;
    cmd_rmem_q  <= cmd_rmem_d;
    cmd_addr_q  <= cmd_addr_d;
    cmd_wdata_q <= cmd_wdata_d;
    cmd_bad_q   <= cmd_bad_d;
  end

  // Outputs: memory is driven only in a non-reset ACCESS cycle, illegal codes become a no-op access.
  always_comb begin
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    wmem       = 4'b0000;
    rmem       = 5'b00000;
    mem_addr   = 32'h0;
    store_data = 32'h0;
    busy       = (state_q == ACCESS);
    if (state_q == ACCESS && !rst) begin
      p0_gnt     = ~win_q;
      p1_gnt     = win_q;
      mem_addr   = {{(32-AW){1'b0}}, cmd_addr_q};
      store_data = cmd_wdata_q;
      if (!cmd_bad_q) begin
        wmem = cmd_wmem_q;
        rmem = cmd_rmem_q;
      end
    end
  end

  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, arbitration/reset sequences, and randomized
// two-requester traffic against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          p0_req, p1_req;
  logic [3:0]    p0_wmem, p1_wmem;
  logic [4:0]    p0_rmem, p1_rmem;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, busy;
  logic [31:0]   p0_rdata, p1_rdata;
  logic [3:0]    wmem;
  logic [4:0]    rmem;
  logic [31:0]   mem_addr, store_data, load_data;

  logic          b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_p0_err, b_p1_err, b_busy;
  logic [31:0]   b_p0_rdata, b_p1_rdata;
  logic [3:0]    b_wmem;
  logic [4:0]    b_rmem;
  logic [31:0]   b_mem_addr, b_store_data;

  dmem_arbiter #(.AW(AW), .ARB_MODE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wmem(p0_wmem), .p0_rmem(p0_rmem), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wmem(p1_wmem), .p1_rmem(p1_rmem), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr), .store_data(store_data),
    .load_data(load_data), .busy(busy));

  dmem_arbiter #(.AW(AW), .ARB_MODE(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wmem(p0_wmem), .p0_rmem(p0_rmem), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err),
    .p1_req(p1_req), .p1_wmem(p1_wmem), .p1_rmem(p1_rmem), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
    .wmem(b_wmem), .rmem(b_rmem), .mem_addr(b_mem_addr), .store_data(b_store_data),
    .load_data(32'h0), .busy(b_busy));

  // Byte-lane memory: store data is right-aligned into the selected lanes, loads are right-aligned
  // and optionally sign-extended from the top selected byte.
  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [3:0] wm,
                                           input logic [31:0] wd);
    logic [31:0] r;
    int k;
    r = old;
    k = 0;
    for (int i = 0; i < 4; i++)
      if (wm[i]) begin r[8*i +: 8] = wd[8*k +: 8]; k++; end
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [4:0] rm);
    logic [31:0] r;
    int k;
    r = 32'h0;
    k = 0;
    for (int i = 0; i < 4; i++)
      if (rm[i]) begin r[8*k +: 8] = w[8*i +: 8]; k++; end
    if (rm[4] && k > 0 && k < 4 && r[8*k-1])
      for (int j = 8*k; j < 32; j++) r[j] = 1'b1;
    return r;
  endfunction

  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge clk)
    if (wmem != 4'h0) mem[mem_addr[5:0]] <= st_merge(mem[mem_addr[5:0]], wmem, store_data);
  assign load_data = ld_ext(mem[mem_addr[5:0]], rmem);

  // Reference model: legality as "aligned contiguous run of 1, 2 or 4 lanes".
  function automatic bit lanes_ok(input logic [3:0] l);
    int w, off;
    if (l == 4'h0) return 1'b1;
    w = $countones(l);
    off = 0;
    for (int i = 3; i >= 0; i--) if (l[i]) off = i;
    return (w == 1 || w == 2 || w == 4) && (off % w == 0) &&
           (l == 4'(((1 << w) - 1) << off));
  endfunction

  function automatic bit cmd_ok(input logic [3:0] wm, input logic [4:0] rm);
    bit r_ok;
    r_ok = (rm == 5'h0) || (rm[3:0] != 4'h0 && lanes_ok(rm[3:0]) && !(rm[4] && rm[3:0] == 4'hF));
    return lanes_ok(wm) && r_ok;
  endfunction

  logic [31:0] ref_mem [64] = '{default: 32'h0};
  logic [31:0] ref_rd [2] = '{32'h0, 32'h0};
  bit          last = 1'b1;

  task automatic model_txn(input int p, input logic [3:0] wm, input logic [4:0] rm,
                           input logic [AW-1:0] a, input logic [31:0] wd,
                           output logic [31:0] exp_rd, output bit exp_err);
    exp_err = !cmd_ok(wm, rm);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (rm != 5'h0) exp_rd = ld_ext(ref_mem[a[5:0]], rm);
      if (wm != 4'h0) ref_mem[a[5:0]] = st_merge(ref_mem[a[5:0]], wm, wd);
    end
    ref_rd[p] = exp_rd;
    last = (p != 0);
  endtask

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic [3:0] w, input logic [4:0] rm,
                          input logic [AW-1:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = r; p0_wmem = w; p0_rmem = rm; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = r; p1_wmem = w; p1_rmem = rm; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic chk_idle_mem(input string name);
    chk({name, "_mem_a"}, {wmem, rmem, mem_addr, store_data}, 0);
    chk({name, "_mem_b"}, {b_wmem, b_rmem, b_mem_addr, b_store_data, b_busy}, 0);
  endtask

  // Single-requester transaction; starts and ends just after a clock edge in an IDLE cycle.
  task automatic do_txn(input string name, input int p, input logic [3:0] wm, input logic [4:0] rm,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] m_rd;
    bit          m_err;
    set_port(p, 1'b1, wm, rm, a, wd);
    @(posedge clk); #1;
    chk({name, "_gnt"}, {p1_gnt, p0_gnt, busy}, {(p == 1), (p == 0), 1'b1});
    chk({name, "_memcmd"}, {wmem, rmem, mem_addr},
        {(exp_err ? 4'h0 : wm), (exp_err ? 5'h0 : rm), 20'h0, a});
    model_txn(p, wm, rm, a, wd, m_rd, m_err);
    @(posedge clk); #1;
    set_port(p, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    chk({name, "_rvalid"}, {p1_rvalid, p0_rvalid, busy}, {(p == 1), (p == 0), 1'b0});
    chk({name, "_rdata"}, (p == 0) ? p0_rdata : p1_rdata, exp_rd);
    chk({name, "_err"}, {p1_err, p0_err}, {(p == 1) && exp_err, (p == 0) && exp_err});
    chk_idle_mem(name);
  endtask

  typedef struct {
    string         name;
    int            port;
    logic [3:0]    wm;
    logic [4:0]    rm;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   exp_rd;
    bit            exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  bit          pend [2];
  logic [3:0]  cw [2];
  logic [4:0]  cr [2];
  logic [AW-1:0] ca [2];
  logic [31:0] cd [2];
  logic [3:0]  lw [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  logic [3:0]  ll [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};

  task automatic new_cmd(input int q);
    int r;
    r = int'($urandom % 8);
    pend[q] = 1'b1;
    ca[q] = AW'(32 + ($urandom % 16));
    cd[q] = $urandom;
    if (r == 0) begin
      cw[q] = 4'($urandom);
      cr[q] = 5'($urandom);
    end else begin
      cw[q] = (r < 4) ? lw[$urandom % 8] : 4'h0;
      cr[q] = (r >= 3) ? {1'($urandom), ll[$urandom % 6]} : 5'h0;
      if (r == 7) cr[q] = 5'b01111;
    end
  endtask

  initial begin
    logic [31:0] e_rd;
    bit          e_err;
    int          w, o;

    tbl[0]  = '{"st_deadbeef", 0, 4'hF, 5'h00, 12'd5, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{"ld_deadbeef", 0, 4'h0, 5'h0F, 12'd5, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{"st_80ff",     1, 4'hF, 5'h00, 12'd5, 32'h000080FF, 32'h0,        1'b0};
    tbl[3]  = '{"ld_sb0",      1, 4'h0, 5'h11, 12'd5, 32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{"ld_ub1",      1, 4'h0, 5'h02, 12'd5, 32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{"ld_sh_hi",    1, 4'h0, 5'h1C, 12'd5, 32'h0,        32'h00000000, 1'b0};
    tbl[6]  = '{"bad_wmem",    0, 4'h5, 5'h00, 12'd5, 32'h12345678, 32'h0,        1'b1};
    tbl[7]  = '{"rb_unchanged",0, 4'h0, 5'h0F, 12'd5, 32'h0,        32'h000080FF, 1'b0};
    tbl[8]  = '{"st_aaaa",     0, 4'hF, 5'h00, 12'd3, 32'hAAAAAAAA, 32'h0,        1'b0};
    tbl[9]  = '{"st_ld_same",  0, 4'hF, 5'h0F, 12'd3, 32'h55555555, 32'hAAAAAAAA, 1'b0};
    tbl[10] = '{"rb_5555",     0, 4'h0, 5'h0F, 12'd3, 32'h0,        32'h55555555, 1'b0};
    tbl[11] = '{"noop",        1, 4'h0, 5'h00, 12'd3, 32'h0,        32'h0,        1'b0};
    tbl[12] = '{"bad_rmem",    1, 4'h0, 5'h10, 12'd3, 32'h0,        32'h0,        1'b1};
    tbl[13] = '{"bad_sfull",   0, 4'h0, 5'h1F, 12'd3, 32'h0,        32'h0,        1'b1};
    tbl[14] = '{"st_h_lo",     1, 4'h3, 5'h00, 12'd9, 32'h0000BEEF, 32'h0,        1'b0};
    tbl[15] = '{"st_h_hi",     1, 4'hC, 5'h00, 12'd9, 32'h0000CAFE, 32'h0,        1'b0};
    tbl[16] = '{"rb_halves",   1, 4'h0, 5'h0F, 12'd9, 32'h0,        32'hCAFEBEEF, 1'b0};

    set_port(0, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    set_port(1, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ctl", {p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, p1_err, p0_err, busy}, 0);
    chk("reset_rdata", {p1_rdata, p0_rdata}, 0);
    chk_idle_mem("reset");

    // Both ports held with no-op commands for four back-to-back transactions.
    set_port(0, 1'b1, 4'h0, 5'h0, '0, 32'h0);
    set_port(1, 1'b1, 4'h0, 5'h0, '0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rr_gnt", {p1_gnt, p0_gnt}, (k % 2) ? 2'b10 : 2'b01);
      chk("fp_gnt", {b_p1_gnt, b_p0_gnt}, 2'b01);
      if (k == 3) begin
        set_port(0, 1'b0, 4'h0, 5'h0, '0, 32'h0);
        set_port(1, 1'b0, 4'h0, 5'h0, '0, 32'h0);
      end
      @(posedge clk); #1;
      chk("rr_rvalid", {p1_rvalid, p0_rvalid, p1_err, p0_err, p1_rdata, p0_rdata},
          {((k % 2) ? 2'b10 : 2'b01), 2'b00, 64'h0});
      chk("fp_rvalid", {b_p1_rvalid, b_p0_rvalid, b_p1_err, b_p0_err, b_p1_rdata, b_p0_rdata},
          {2'b01, 2'b00, 64'h0});
    end
    last = 1'b1;

    for (int i = 0; i < NV; i++)
      do_txn(tbl[i].name, tbl[i].port, tbl[i].wm, tbl[i].rm, tbl[i].addr, tbl[i].wd,
             tbl[i].exp_rd, tbl[i].exp_err);

    // Reset during the ACCESS cycle of a store: the store must not land and no rvalid follows.
    do_txn("st7_init", 0, 4'hF, 5'h00, 12'd7, 32'h0BADF00D, 32'h0, 1'b0);
    set_port(0, 1'b1, 4'hF, 5'h00, 12'd7, 32'h12345678);
    @(posedge clk); #1;
    chk("rst_acc_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_acc_forced0", {wmem, rmem}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_port(0, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    chk("rst_acc_after", {busy, p1_rvalid, p0_rvalid, p0_rdata, p1_rdata}, 0);
    @(posedge clk); #1;
    chk("rst_acc_norvalid", {busy, p1_rvalid, p0_rvalid}, 0);
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
    last = 1'b1;
    do_txn("rb_word7", 0, 4'h0, 5'h0F, 12'd7, 32'h0, 32'h0BADF00D, 1'b0);

    // Randomized contention between both requesters.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend[0] && !pend[1]) new_cmd(int'($urandom % 2));
      for (int q = 0; q < 2; q++)
        set_port(q, pend[q], cw[q], cr[q], ca[q], cd[q]);
      w = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
      o = 1 - w;
      @(posedge clk); #1;
      chk("rnd_gnt", {p1_gnt, p0_gnt, busy}, {(w == 1), (w == 0), 1'b1});
      model_txn(w, cw[w], cr[w], ca[w], cd[w], e_rd, e_err);
      chk("rnd_memcmd", {wmem, rmem, mem_addr[AW-1:0], store_data},
          {(e_err ? 4'h0 : cw[w]), (e_err ? 5'h0 : cr[w]), ca[w], cd[w]});
      @(posedge clk); #1;
      chk("rnd_rvalid", {p1_rvalid, p0_rvalid, p1_err, p0_err},
          {(w == 1), (w == 0), (w == 1) && e_err, (w == 0) && e_err});
      chk("rnd_rdata_win", (w == 0) ? p0_rdata : p1_rdata, e_rd);
      chk("rnd_rdata_hold", (o == 0) ? p0_rdata : p1_rdata, ref_rd[o]);
      chk("rnd_idle_mem", {busy, wmem, rmem, mem_addr, store_data}, 0);
      pend[w] = 1'b0;
      if ($urandom % 2 == 0) new_cmd(w);
      if (!pend[o] && ($urandom % 3 == 0)) new_cmd(o);
    end
    set_port(0, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    set_port(1, 1'b0, 4'h0, 5'h0, '0, 32'h0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
